// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        DATA,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int CNT_W          = 16;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Collects little-endian bytes into 32-bit words; word_valid pulses
// combinationally with the 4th byte so the word is usable on that same edge.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [1:0]  lane;
    logic [23:0] partial;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane    <= '0;
            partial <= '0;
        end else if (clear) begin
            lane    <= '0;
            partial <= '0;
        end else if (byte_valid) begin
            case (lane)
                2'd0:    partial[7:0]   <= byte_data;
                2'd1:    partial[15:8]  <= byte_data;
                2'd2:    partial[23:16] <= byte_data;
                default: partial        <= partial;
            endcase
            lane <= lane + 2'd1;
        end
    end

    assign word_valid = byte_valid && (lane == 2'(BYTES_PER_WORD - 1));
    assign word_data  = {byte_data, partial};

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed program image into instruction
// memory and keeps the core in reset until the image has been verified.
module imem_loader
    import loader_pkg::*;
#(
    parameter int IMEM_ADDR_W = 8,
    parameter int DATA_W      = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    input  logic                   reload,
    output logic                   imem_we,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0]      imem_wdata,
    output logic                   core_reset,
    output logic                   done,
    output logic                   error
);

    localparam logic [31:0] DEPTH = 32'd1 << IMEM_ADDR_W;

    loader_state_t    state;
    logic [7:0]       cnt_lo;
    logic [CNT_W-1:0] word_total;
    logic [CNT_W-1:0] word_cnt;
    logic [7:0]       chk;

    logic             accept;
    logic             restart;
    logic [CNT_W-1:0] hdr_n;
    logic             word_valid;
    logic [31:0]      word_data;

    assign accept  = in_valid && in_ready;
    assign restart = reload && ((state == DONE) || (state == ERROR));
    assign hdr_n   = {in_data, cnt_lo};

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (restart),
        .byte_valid (accept && (state == DATA)),
        .byte_data  (in_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    // The write register is separate from the packer, so the byte accepted
    // during a write cycle already belongs to the next word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= HDR_LO;
            in_ready   <= 1'b0;
            cnt_lo     <= '0;
            word_total <= '0;
            word_cnt   <= '0;
            chk        <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_reset <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                HDR_LO: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        cnt_lo <= in_data;
                        state  <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (accept) begin
                        word_total <= hdr_n;
                        word_cnt   <= '0;
                        chk        <= '0;
                        if ({16'd0, hdr_n} > DEPTH) begin
                            state    <= ERROR;
                            error    <= 1'b1;
                            in_ready <= 1'b0;
                        end else if (hdr_n == '0) begin
                            state <= CHECK;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        chk <= chk ^ in_data;
                        if (word_valid) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= word_cnt[IMEM_ADDR_W-1:0];
                            imem_wdata <= word_data;
                            word_cnt   <= word_cnt + CNT_W'(1);
                            if (word_cnt + CNT_W'(1) == word_total) begin
                                state <= CHECK;
                            end
                        end
                    end
                end
                CHECK: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (in_data == chk) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                DONE, ERROR: begin
                    if (reload) begin
                        state      <= HDR_LO;
                        in_ready   <= 1'b1;
                        core_reset <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        chk        <= '0;
                        word_cnt   <= '0;
                        imem_addr  <= '0;
                    end else if (state == DONE) begin
                        core_reset <= 1'b0;
                    end
                end
                default: begin
                    state    <= HDR_LO;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a scoreboard of expected memory writes
// is filled as words are streamed and drained by a write monitor.
module tb_imem_loader;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        reload = 1'b0;
    logic        in_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_reset;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;
    int we_count = 0;
    int data_stalls = 0;
    int we0;
    int bad;
    int s;
    wr_t sb[$];
    wr_t e;
    logic [31:0] mem [256];
    logic [31:0] gold [256];
    logic [31:0] img [256];

    imem_loader #(.IMEM_ADDR_W(8), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory model and scoreboard drain; samples on the falling edge.
    always @(negedge clk) begin
        if (reset && imem_we) begin
            if (sb.size() == 0) begin
                checkOutput("we_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("we_addr", {24'd0, imem_addr}, {24'd0, e.addr});
                checkOutput("we_data", imem_wdata, e.data);
            end
            mem[imem_addr] = imem_wdata;
            we_count++;
        end
    end

    task automatic applyStimulus(input logic [7:0] b, input int gap, output int stalls);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        stalls   = 0;
        while (!in_ready && stalls < 200) begin
            @(negedge clk);
            stalls++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    function automatic int pick_gap(input int max_gap);
        return (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
    endfunction

    task automatic sendImage(input int n, input int max_gap, input bit force_chk, input logic [7:0] forced);
        logic [7:0]  c;
        logic [7:0]  b;
        logic [15:0] nn;
        logic [31:0] w;
        int st;
        c  = 8'h00;
        nn = n[15:0];
        data_stalls = 0;
        applyStimulus(nn[7:0], pick_gap(max_gap), st);
        applyStimulus(nn[15:8], pick_gap(max_gap), st);
        for (int k = 0; k < n; k++) begin
            w = img[k];
            sb.push_back('{addr: k[7:0], data: w});
            for (int j = 0; j < 4; j++) begin
                b = w[8*j +: 8];
                c = c ^ b;
                applyStimulus(b, pick_gap(max_gap), st);
                data_stalls += st;
            end
        end
        applyStimulus(force_chk ? forced : c, pick_gap(max_gap), st);
    endtask

    task automatic pulseReload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic checkResetValues(input string p);
        checkOutput({p, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        checkOutput({p, "_imem_we"}, {31'd0, imem_we}, 32'd0);
        checkOutput({p, "_imem_addr"}, {24'd0, imem_addr}, 32'd0);
        checkOutput({p, "_imem_wdata"}, imem_wdata, 32'd0);
        checkOutput({p, "_core_reset"}, {31'd0, core_reset}, 32'd1);
        checkOutput({p, "_done"}, {31'd0, done}, 32'd0);
        checkOutput({p, "_error"}, {31'd0, error}, 32'd0);
    endtask

    task automatic clearMem();
        for (int i = 0; i < 256; i++) mem[i] = 32'hDEADBEEF;
    endtask

    initial begin
        clearMem();
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        reset = 1'b1;

        // Two-word image with matching checksum
        img[0] = 32'hfd010113;
        img[1] = 32'h02812623;
        we0 = we_count;
        sendImage(2, 0, 1'b0, 8'h00);
        checkOutput("t1_done", {31'd0, done}, 32'd1);
        checkOutput("t1_core_reset_hold", {31'd0, core_reset}, 32'd1);
        checkOutput("t1_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        checkOutput("t1_core_reset_fall", {31'd0, core_reset}, 32'd0);
        checkOutput("t1_we_count", we_count - we0, 32'd2);
        checkOutput("t1_mem0", mem[0], 32'hfd010113);
        checkOutput("t1_mem1", mem[1], 32'h02812623);
        pulseReload();
        checkOutput("t1_reload_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("t1_reload_done", {31'd0, done}, 32'd0);
        checkOutput("t1_reload_core_reset", {31'd0, core_reset}, 32'd1);

        // Same image, wrong checksum
        sendImage(2, 0, 1'b1, 8'h00);
        repeat (3) @(negedge clk);
        checkOutput("t2_error", {31'd0, error}, 32'd1);
        checkOutput("t2_done", {31'd0, done}, 32'd0);
        checkOutput("t2_core_reset", {31'd0, core_reset}, 32'd1);
        checkOutput("t2_in_ready", {31'd0, in_ready}, 32'd0);
        pulseReload();
        checkOutput("t2_reload_error", {31'd0, error}, 32'd0);
        checkOutput("t2_reload_in_ready", {31'd0, in_ready}, 32'd1);

        // Empty image
        we0 = we_count;
        sendImage(0, 0, 1'b0, 8'h00);
        checkOutput("t3_done", {31'd0, done}, 32'd1);
        checkOutput("t3_no_we", we_count - we0, 32'd0);
        pulseReload();

        // Oversize header rejected right after CNT_HI
        applyStimulus(8'h01, 0, s);
        applyStimulus(8'h01, 0, s);
        checkOutput("t4_error", {31'd0, error}, 32'd1);
        checkOutput("t4_in_ready", {31'd0, in_ready}, 32'd0);
        pulseReload();

        // Full-depth image streamed back to back
        for (int i = 0; i < 256; i++) img[i] = $urandom;
        clearMem();
        we0 = we_count;
        sendImage(256, 0, 1'b0, 8'h00);
        checkOutput("t5_data_stalls", data_stalls, 32'd0);
        checkOutput("t5_done", {31'd0, done}, 32'd1);
        checkOutput("t5_last_addr", {24'd0, imem_addr}, 32'h000000FF);
        checkOutput("t5_we_count", we_count - we0, 32'd256);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== img[i]) bad++;
        checkOutput("t5_mem", bad, 32'd0);
        pulseReload();

        // Asynchronous reset after word 1 has been written
        for (int i = 0; i < 41; i++) img[i] = $urandom;
        applyStimulus(8'd41, 0, s);
        applyStimulus(8'd0, 0, s);
        for (int k = 0; k < 2; k++) begin
            sb.push_back('{addr: k[7:0], data: img[k]});
            for (int j = 0; j < 4; j++) applyStimulus(img[k][8*j +: 8], 0, s);
        end
        @(negedge clk);
        checkOutput("t6_sb_drained", sb.size(), 32'd0);
        reset = 1'b0;
        #1;
        checkResetValues("t6_midreset");
        @(negedge clk);
        reset = 1'b1;
        clearMem();
        we0 = we_count;
        sendImage(41, 0, 1'b0, 8'h00);
        checkOutput("t6_done", {31'd0, done}, 32'd1);
        checkOutput("t6_we_count", we_count - we0, 32'd41);
        bad = 0;
        for (int i = 0; i < 41; i++) begin
            if (mem[i] !== img[i]) bad++;
            gold[i] = mem[i];
        end
        checkOutput("t6_mem", bad, 32'd0);
        @(negedge clk);
        checkOutput("t6_core_run", {31'd0, core_reset}, 32'd0);
        pulseReload();

        // Same image with random valid gaps
        clearMem();
        we0 = we_count;
        sendImage(41, 1, 1'b0, 8'h00);
        checkOutput("t7_done", {31'd0, done}, 32'd1);
        checkOutput("t7_we_count", we_count - we0, 32'd41);
        bad = 0;
        for (int i = 0; i < 41; i++) if (mem[i] !== gold[i]) bad++;
        checkOutput("t7_mem_vs_gapless", bad, 32'd0);
        checkOutput("t7_sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
